// File: rtl/lag_scan_pkg.sv
// Shared types and default sizing for the lag-scan scheduler.
package lag_scan_pkg;

    localparam int DEF_NUM_INPUTS    = 8;
    localparam int DEF_LAG_WIDTH     = 20;
    localparam int DEF_INC_WIDTH     = 12;
    localparam int DEF_DWELL_WIDTH   = 24;
    localparam int DEF_SETTLE_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_INTEGRATE,
        ST_REQUEST,
        ST_WAIT_TX,
        ST_ADVANCE,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/lag_step_unit.sv
// One channel of the lag scan: shadowed config, current lag, and the
// "would the next step reach start+len" compare done one bit wider so a
// lag near the top of the range never wraps.
module lag_step_unit
    import lag_scan_pkg::*;
#(
    parameter int LAG_WIDTH = DEF_LAG_WIDTH,
    parameter int INC_WIDTH = DEF_INC_WIDTH
) (
    input  logic                 intclk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [LAG_WIDTH-1:0] lag_start,
    input  logic [LAG_WIDTH-1:0] lag_len,
    input  logic [INC_WIDTH-1:0] lag_increment,
    output logic [LAG_WIDTH-1:0] lag_current,
    output logic                 finished
);

    logic [LAG_WIDTH-1:0] start_q;
    logic [LAG_WIDTH-1:0] len_q;
    logic [INC_WIDTH-1:0] inc_q;
    logic [LAG_WIDTH:0]   next_sum;
    logic [LAG_WIDTH:0]   limit;

    assign next_sum = {1'b0, lag_current} + {{(LAG_WIDTH+1-INC_WIDTH){1'b0}}, inc_q};
    assign limit    = {1'b0, start_q} + {1'b0, len_q};
    // A zero increment can never make progress, so treat it as done.
    assign finished = (inc_q == '0) || (next_sum >= limit);

    // Latch config at scan load; advance the lag only while not finished.
    always_ff @(posedge intclk or negedge reset_n) begin
        if (!reset_n) begin
            start_q     <= '0;
            len_q       <= '0;
            inc_q       <= '0;
            lag_current <= '0;
        end else if (load) begin
            start_q     <= lag_start;
            len_q       <= lag_len;
            inc_q       <= lag_increment;
            lag_current <= lag_start;
        end else if (step && !finished) begin
            lag_current <= next_sum[LAG_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/lag_scan_scheduler.sv
// Lag-scan sequencer: load lags, settle, integrate for the dwell, hand the
// frame to the packet generator, then step every enabled channel.
module lag_scan_scheduler
    import lag_scan_pkg::*;
#(
    parameter int NUM_INPUTS    = DEF_NUM_INPUTS,
    parameter int LAG_WIDTH     = DEF_LAG_WIDTH,
    parameter int INC_WIDTH     = DEF_INC_WIDTH,
    parameter int DWELL_WIDTH   = DEF_DWELL_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                                 intclk,
    input  logic                                 reset_n,
    input  logic                                 enable,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [NUM_INPUTS-1:0]                scan_mask,
    input  logic [NUM_INPUTS-1:0][LAG_WIDTH-1:0] lag_start,
    input  logic [NUM_INPUTS-1:0][LAG_WIDTH-1:0] lag_len,
    input  logic [NUM_INPUTS-1:0][INC_WIDTH-1:0] lag_increment,
    input  logic [DWELL_WIDTH-1:0]               dwell,
    input  logic                                 tx_ready,
    input  logic                                 tx_done,
    output logic [NUM_INPUTS-1:0][LAG_WIDTH-1:0] lag_current,
    output logic                                 integrate,
    output logic                                 capture_start,
    output logic                                 tx_req,
    output logic                                 busy,
    output logic [15:0]                          step_index,
    output logic                                 done
);

    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    scan_state_t            state, state_nx;
    logic [SCW-1:0]         settle_cnt;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic [NUM_INPUTS-1:0]  mask_q;
    logic [NUM_INPUTS-1:0]  fin;
    logic                   all_fin;
    logic                   run_ok;
    logic                   load_en;
    logic                   step_en;
    logic                   settle_last;
    logic                   dwell_last;

    assign run_ok      = enable && !abort;
    assign load_en     = (state == ST_LOAD) && run_ok;
    assign step_en     = (state == ST_ADVANCE) && run_ok;
    assign settle_last = (settle_cnt == SCW'(SETTLE_CYCLES - 1));
    assign dwell_last  = (dwell_cnt <= DWELL_WIDTH'(1));
    assign all_fin     = &(fin | ~mask_q);

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        lag_step_unit #(
            .LAG_WIDTH (LAG_WIDTH),
            .INC_WIDTH (INC_WIDTH)
        ) u_step (
            .intclk        (intclk),
            .reset_n       (reset_n),
            .load          (load_en),
            .step          (step_en && mask_q[i]),
            .lag_start     (lag_start[i]),
            .lag_len       (lag_len[i]),
            .lag_increment (lag_increment[i]),
            .lag_current   (lag_current[i]),
            .finished      (fin[i])
        );
    end

    // Next-state and Moore outputs; abort/disable overrides everything.
    always_comb begin
        state_nx      = state;
        integrate     = 1'b0;
        capture_start = 1'b0;
        tx_req        = 1'b0;
        busy          = (state != ST_IDLE);
        done          = 1'b0;
        case (state)
            ST_IDLE:      if (start && enable) state_nx = ST_LOAD;
            ST_LOAD: begin
                capture_start = 1'b1;
                state_nx      = ST_SETTLE;
            end
            ST_SETTLE:    if (settle_last) state_nx = ST_INTEGRATE;
            ST_INTEGRATE: begin
                integrate = 1'b1;
                if (dwell_last) state_nx = ST_REQUEST;
            end
            ST_REQUEST: begin
                tx_req = 1'b1;
                if (tx_ready) state_nx = ST_WAIT_TX;
            end
            ST_WAIT_TX:   if (tx_done) state_nx = ST_ADVANCE;
            ST_ADVANCE:   state_nx = all_fin ? ST_DONE : ST_SETTLE;
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default:      state_nx = ST_IDLE;
        endcase
        if (state != ST_IDLE && !run_ok) state_nx = ST_IDLE;
    end

    // State register, settle/dwell counters, shadow mask/dwell, step count.
    always_ff @(posedge intclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            dwell_cnt  <= '0;
            dwell_q    <= '0;
            mask_q     <= '0;
            step_index <= '0;
        end else begin
            state      <= state_nx;
            settle_cnt <= (state == ST_SETTLE && !settle_last) ? settle_cnt + 1'b1 : '0;
            // Reloaded every settle cycle so it is ready on the last one.
            if (state == ST_SETTLE)
                dwell_cnt <= (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;
            else if (state == ST_INTEGRATE)
                dwell_cnt <= dwell_cnt - 1'b1;
            if (load_en) begin
                mask_q     <= scan_mask;
                dwell_q    <= dwell;
                step_index <= '0;
            end
            if (step_en && !all_fin && step_index != 16'hFFFF)
                step_index <= step_index + 1'b1;
        end
    end

endmodule

// File: tb/tb_lag_scan_scheduler.sv
module tb_lag_scan_scheduler;

    localparam int N  = 2;
    localparam int LW = 20;
    localparam int IW = 12;
    localparam int DW = 24;
    localparam int SC = 4;

    logic                  intclk = 1'b0;
    logic                  reset_n;
    logic                  enable;
    logic                  start;
    logic                  abort;
    logic [N-1:0]          scan_mask;
    logic [N-1:0][LW-1:0]  lag_start;
    logic [N-1:0][LW-1:0]  lag_len;
    logic [N-1:0][IW-1:0]  lag_increment;
    logic [DW-1:0]         dwell;
    logic                  tx_ready;
    logic                  tx_done;
    logic [N-1:0][LW-1:0]  lag_current;
    logic                  integrate;
    logic                  capture_start;
    logic                  tx_req;
    logic                  busy;
    logic [15:0]           step_index;
    logic                  done;

    typedef struct {
        logic [LW-1:0] l0;
        logic [LW-1:0] l1;
        logic [15:0]   st;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 intclk = ~intclk;

    lag_scan_scheduler #(
        .NUM_INPUTS(N), .LAG_WIDTH(LW), .INC_WIDTH(IW),
        .DWELL_WIDTH(DW), .SETTLE_CYCLES(SC)
    ) dut (
        .intclk(intclk), .reset_n(reset_n), .enable(enable), .start(start),
        .abort(abort), .scan_mask(scan_mask), .lag_start(lag_start),
        .lag_len(lag_len), .lag_increment(lag_increment), .dwell(dwell),
        .tx_ready(tx_ready), .tx_done(tx_done), .lag_current(lag_current),
        .integrate(integrate), .capture_start(capture_start), .tx_req(tx_req),
        .busy(busy), .step_index(step_index), .done(done)
    );

    // Drive config and push the expected per-step lags for a whole scan.
    task automatic cfg_scan(input logic [1:0] m,
                            input logic [LW-1:0] s0, input logic [LW-1:0] l0, input logic [IW-1:0] i0,
                            input logic [LW-1:0] s1, input logic [LW-1:0] l1, input logic [IW-1:0] i1,
                            input logic [DW-1:0] dw, output int nf);
        logic [LW:0] c0, c1, n0, n1, lim0, lim1;
        bit f0, f1;
        int st;
        exp_t e;
        scan_mask = m;
        lag_start[0] = s0; lag_len[0] = l0; lag_increment[0] = i0;
        lag_start[1] = s1; lag_len[1] = l1; lag_increment[1] = i1;
        dwell = dw;
        c0 = {1'b0, s0}; c1 = {1'b0, s1};
        lim0 = {1'b0, s0} + {1'b0, l0};
        lim1 = {1'b0, s1} + {1'b0, l1};
        nf = 0; st = 0;
        forever begin
            e.l0 = c0[LW-1:0]; e.l1 = c1[LW-1:0]; e.st = 16'(st);
            exp_q.push_back(e);
            nf++;
            n0 = c0 + {{(LW+1-IW){1'b0}}, i0};
            n1 = c1 + {{(LW+1-IW){1'b0}}, i1};
            f0 = !m[0] || (i0 == 0) || !(n0 < lim0);
            f1 = !m[1] || (i1 == 0) || !(n1 < lim1);
            if ((f0 && f1) || nf >= 500) break;
            if (!f0) c0 = n0;
            if (!f1) c1 = n1;
            st++;
        end
    endtask

    // Start a scan and act as packet generator; scoreboard each step.
    task automatic run_scan(input int dly, input int exp_dwell, input int exp_frames,
                            input int abort_step, input bit stray);
        int cyc = 0, ilen = 0, rlen = 0, gap = 0, frames = 0;
        bit prev_i = 0, prev_r = 0, got_done = 0, aborted = 0;
        exp_t e;
        @(negedge intclk);
        start = 1'b1;
        while (cyc < 20000) begin
            @(negedge intclk);
            cyc++;
            start = 1'b0; tx_done = 1'b0; tx_ready = 1'b0;
            gap++;
            if (capture_start) gap = 0;
            if (integrate && !prev_i) begin
                total++;
                if (gap !== SC + 1) begin
                    bad++; $display("FAIL settle_gap: got %0d want %0d", gap, SC + 1);
                end
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL extra_step: got step %0d want none", step_index);
                end else begin
                    e = exp_q.pop_front();
                    if (lag_current[0] !== e.l0 || lag_current[1] !== e.l1 || step_index !== e.st) begin
                        bad++;
                        $display("FAIL step_lags: got %h/%h st %0d want %h/%h st %0d",
                                 lag_current[0], lag_current[1], step_index, e.l0, e.l1, e.st);
                    end
                end
                if (stray) begin tx_done = 1'b1; start = 1'b1; end
                if (abort_step >= 0 && step_index == 16'(abort_step)) begin
                    abort = 1'b1; aborted = 1; break;
                end
            end
            if (integrate) ilen++;
            if (!integrate && prev_i) begin
                total++;
                if (ilen !== exp_dwell) begin
                    bad++; $display("FAIL integ_len: got %0d want %0d", ilen, exp_dwell);
                end
                ilen = 0;
            end
            if (tx_req) begin
                rlen++;
                tx_ready = (rlen > dly);
            end
            if (!tx_req && prev_r) begin
                total++;
                if (rlen !== dly + 1) begin
                    bad++; $display("FAIL req_hold: got %0d want %0d", rlen, dly + 1);
                end
                rlen = 0; frames++;
                tx_done = 1'b1; gap = -1;
            end
            if (done) begin got_done = 1; break; end
            prev_i = integrate; prev_r = tx_req;
        end
        if (!aborted) begin
            total++;
            if (!got_done || frames !== exp_frames || exp_q.size() !== 0) begin
                bad++;
                $display("FAIL scan_end: done %0d frames %0d left %0d want done 1 frames %0d left 0",
                         got_done, frames, exp_q.size(), exp_frames);
            end
            @(negedge intclk);
            total++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                bad++; $display("FAIL idle_after_done: busy %b done %b want 0 0", busy, done);
            end
        end
        tx_done = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({busy, integrate, tx_req, done, capture_start} !== 5'b0 || lag_current !== '0 || step_index !== 16'd0) begin
            bad++; $display("FAIL reset_outputs: ctl %b lag %h st %0d want all zero",
                            {busy, integrate, tx_req, done, capture_start}, lag_current, step_index);
        end
        repeat (2) @(negedge intclk);
        reset_n = 1'b1;
        enable = 1'b0; start = 1'b1;
        @(negedge intclk);
        start = 1'b0;
        @(negedge intclk);
        total++;
        if (busy !== 1'b0 || capture_start !== 1'b0) begin
            bad++; $display("FAIL start_disabled: busy %b cap %b want 0 0", busy, capture_start);
        end
        enable = 1'b1;
    endtask

    task automatic test_basic();
        int nf;
        cfg_scan(2'b01, 20'd10, 20'd30, 12'd10, 20'd55, 20'd5, 12'd3, 24'd5, nf);
        run_scan(0, 5, 3, -1, 0);
        total++;
        if (lag_current[0] !== 20'd30 || lag_current[1] !== 20'd55) begin
            bad++; $display("FAIL basic_hold: got %h/%h want 1e/37", lag_current[0], lag_current[1]);
        end
        cfg_scan(2'b11, 20'd100, 20'd25, 12'd10, 20'd5, 20'd60, 12'd15, 24'd3, nf);
        run_scan(0, 3, 4, -1, 0);
    endtask

    task automatic test_dwell_zero();
        int nf;
        cfg_scan(2'b01, 20'd0, 20'd3, 12'd1, 20'd9, 20'd9, 12'd9, 24'd0, nf);
        run_scan(0, 1, 3, -1, 0);
        cfg_scan(2'b01, 20'd7, 20'd100, 12'd0, 20'd9, 20'd9, 12'd9, 24'd0, nf);
        run_scan(0, 1, 1, -1, 0);
        cfg_scan(2'b00, 20'd3, 20'd100, 12'd5, 20'd4, 20'd100, 12'd5, 24'd0, nf);
        run_scan(0, 1, 1, -1, 0);
    endtask

    task automatic test_backpressure();
        int nf;
        cfg_scan(2'b01, 20'd0, 20'd2, 12'd1, 20'd1, 20'd1, 12'd1, 24'd2, nf);
        run_scan(50, 2, 2, -1, 0);
    endtask

    task automatic test_boundary();
        int nf;
        cfg_scan(2'b01, 20'hFFFF0, 20'd16, 12'd8, 20'd0, 20'd0, 12'd0, 24'd2, nf);
        run_scan(1, 2, 2, -1, 1);
    endtask

    task automatic test_abort();
        int nf;
        cfg_scan(2'b01, 20'd0, 20'd100, 12'd10, 20'd2, 20'd2, 12'd2, 24'd3, nf);
        run_scan(0, 3, 10, 2, 0);
        @(negedge intclk);
        abort = 1'b0;
        total++;
        if (integrate !== 1'b0 || busy !== 1'b0 || tx_req !== 1'b0 || step_index !== 16'd2 || lag_current[0] !== 20'd20) begin
            bad++; $display("FAIL abort_state: int %b busy %b req %b st %0d lag %h want 0 0 0 2 14",
                            integrate, busy, tx_req, step_index, lag_current[0]);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge intclk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || step_index !== 16'd2) begin
                bad++; $display("FAIL abort_quiet: done %b busy %b st %0d want 0 0 2", done, busy, step_index);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_wait_tx();
        int nf, k;
        cfg_scan(2'b01, 20'd10, 20'd30, 12'd10, 20'd55, 20'd5, 12'd3, 24'd2, nf);
        exp_q.delete();
        @(negedge intclk);
        start = 1'b1;
        @(negedge intclk);
        start = 1'b0;
        k = 0;
        while (!tx_req && k < 200) begin @(negedge intclk); k++; end
        tx_ready = 1'b1;
        @(negedge intclk);
        tx_ready = 1'b0;
        total++;
        if (tx_req !== 1'b0 || busy !== 1'b1 || k >= 200) begin
            bad++; $display("FAIL wait_tx_entry: req %b busy %b wait %0d want 0 1 <200", tx_req, busy, k);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({busy, integrate, tx_req, done, capture_start} !== 5'b0 || lag_current !== '0 || step_index !== 16'd0) begin
            bad++; $display("FAIL async_reset: ctl %b lag %h st %0d want all zero",
                            {busy, integrate, tx_req, done, capture_start}, lag_current, step_index);
        end
        @(negedge intclk);
        reset_n = 1'b1;
        cfg_scan(2'b01, 20'd10, 20'd30, 12'd10, 20'd55, 20'd5, 12'd3, 24'd2, nf);
        run_scan(0, 2, 3, -1, 0);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; start = 1'b0; abort = 1'b0;
        scan_mask = '0; lag_start = '0; lag_len = '0; lag_increment = '0;
        dwell = '0; tx_ready = 1'b0; tx_done = 1'b0;
        test_reset();
        test_basic();
        test_dwell_zero();
        test_backpressure();
        test_boundary();
        test_abort();
        test_reset_wait_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
